// File: rtl/i2s_audio_receiver_pkg.sv
// Shared I2S definitions: default sample width, channel select levels and
// receiver state encoding. The transmitter side uses the same constants so
// both ends agree on which lrclk level means left.
package i2s_audio_receiver_pkg;

    localparam int I2S_WIDTH_DEF = 16;

    // lrclk level for each channel (Philips: low = left)
    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// Purpose : brings bclk/lrclk/din into the clk domain and flags bclk rising edges.
// Latency : SYNC_STAGES+1 clk from an input change to o_bclk_rise / o_lrclk / o_din.
// Backpr. : none; free-running, one pulse per detected bclk rise.
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   i_bclk/i_lrclk/i_din raw asynchronous I2S inputs
//   o_bclk_rise         one-clk pulse per bclk rising edge
//   o_lrclk, o_din      synchronised lrclk/data, aligned with o_bclk_rise
// SYNC_STAGES must be at least 2.
module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_bclk,
    input  logic i_lrclk,
    input  logic i_din,
    output logic o_bclk_rise,
    output logic o_lrclk,
    output logic o_din
);

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lr_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_bclk_d;
    logic                   r_rise;
    logic                   r_lrclk;
    logic                   r_din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bclk_sync <= '0;
            r_lr_sync   <= '0;
            r_din_sync  <= '0;
            r_bclk_d    <= 1'b0;
            r_rise      <= 1'b0;
            r_lrclk     <= 1'b0;
            r_din       <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i_bclk};
            r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], i_lrclk};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], i_din};
            r_bclk_d    <= r_bclk_sync[SYNC_STAGES-1];
            // Registered edge pulse; lrclk/din get the same extra stage so
            // they stay aligned with the pulse.
            r_rise      <= r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_d;
            r_lrclk     <= r_lr_sync[SYNC_STAGES-1];
            r_din       <= r_din_sync[SYNC_STAGES-1];
        end
    end

    assign o_bclk_rise = r_rise;
    assign o_lrclk     = r_lrclk;
    assign o_din       = r_din;

endmodule

// File: rtl/i2s_audio_receiver.sv
// Purpose : Philips I2S deserialiser producing WIDTH-bit left/right PCM pairs.
// Latency : sample_valid SYNC_STAGES+2 clk after the bclk rise carrying the right LSB.
// Backpr. : none; the stream cannot be stalled, each pair is presented once.
//
// Ports:
//   clk, reset            system clock (>= 4x bclk), async active-high reset
//   i2s_bclk/lrclk/din    oversampled I2S inputs (lrclk 0 = left)
//   audio_l, audio_r      last complete pair, two's complement
//   sample_valid          one-clk strobe when audio_l/audio_r update
//   locked                set by the first delivered pair, held until reset
//   frame_err             sticky short-slot flag
// Optional feature: define I2S_RX_FRAME_CHECK_EN to enable frame_err;
// otherwise frame_err is tied low.
module i2s_audio_receiver
    import i2s_audio_receiver_pkg::*;
#(
    parameter int WIDTH       = I2S_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i2s_bclk,
    input  logic             i2s_lrclk,
    input  logic             i2s_din,
    output logic [WIDTH-1:0] audio_l,
    output logic [WIDTH-1:0] audio_r,
    output logic             sample_valid,
    output logic             locked,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic w_rise;
    logic w_lr;
    logic w_din;

    i2s_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_bclk     (i2s_bclk),
        .i_lrclk    (i2s_lrclk),
        .i_din      (i2s_din),
        .o_bclk_rise(w_rise),
        .o_lrclk    (w_lr),
        .o_din      (w_din)
    );

    rx_state_t        r_state;
    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_lr_last;
    logic             r_lr_seen;
    logic [WIDTH-1:0] r_left_hold;
    logic             r_left_vld;
    logic [WIDTH-1:0] r_audio_l;
    logic [WIDTH-1:0] r_audio_r;
    logic             r_valid;
    logic             r_locked;

    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_word;
    logic             w_room;

    // One-hot slot for the current bit; shifts out to zero once the word is
    // full, so surplus slot bits fall away without a separate guard.
    always_comb begin
        w_bit_mask = {1'b1, {(WIDTH-1){1'b0}}} >> r_bit_cnt;
        w_word     = w_din ? (r_sh | w_bit_mask) : r_sh;
        w_room     = (r_bit_cnt < CNT_W'(WIDTH));
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic r_frame_err;
    logic w_short;
    // The commit rise still contributes one bit, so a full word has
    // bit_cnt == WIDTH-1 at that point.
    assign w_short   = (r_bit_cnt < CNT_W'(WIDTH - 1));
    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_HUNT;
            r_sh        <= '0;
            r_bit_cnt   <= '0;
            r_lr_last   <= LR_LEFT;
            r_lr_seen   <= 1'b0;
            r_left_hold <= '0;
            r_left_vld  <= 1'b0;
            r_audio_l   <= '0;
            r_audio_r   <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (w_rise) begin
                if (!r_lr_seen) begin
                    // First rise after reset only learns the lrclk level, so the
                    // reset value of r_lr_last never fakes a word boundary.
                    r_lr_seen <= 1'b1;
                    r_lr_last <= w_lr;
                end else if (w_lr == r_lr_last) begin
                    r_sh <= w_word;
                    if (w_room) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end else begin
                    // lrclk changed: this rise carries the previous word's LSB.
                    if (r_state == ST_LEFT) begin
                        r_left_hold <= w_word;
                        r_left_vld  <= 1'b1;
                    end else if (r_state == ST_RIGHT) begin
                        r_left_vld <= 1'b0;
                        if (r_left_vld) begin
                            r_audio_l <= r_left_hold;
                            r_audio_r <= w_word;
                            r_valid   <= 1'b1;
                            r_locked  <= 1'b1;
                        end
                    end
`ifdef I2S_RX_FRAME_CHECK_EN
                    if (r_state != ST_HUNT && w_short) begin
                        r_frame_err <= 1'b1;
                    end
`endif
                    r_sh      <= '0;
                    r_bit_cnt <= '0;
                    r_lr_last <= w_lr;
                    r_state   <= (w_lr == LR_RIGHT) ? ST_RIGHT : ST_LEFT;
                end
            end
        end
    end

    assign audio_l      = r_audio_l;
    assign audio_r      = r_audio_r;
    assign sample_valid = r_valid;
    assign locked       = r_locked;

endmodule

// File: tb/tb_i2s_audio_receiver.sv
module tb_i2s_audio_receiver;

    localparam int WIDTH       = 16;
    localparam int SYNC_STAGES = 2;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             i2s_bclk  = 1'b0;
    logic             i2s_lrclk = 1'b0;
    logic             i2s_din   = 1'b0;
    logic [WIDTH-1:0] audio_l;
    logic [WIDTH-1:0] audio_r;
    logic             sample_valid;
    logic             locked;
    logic             frame_err;

    i2s_audio_receiver #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_din     (i2s_din),
        .audio_l     (audio_l),
        .audio_r     (audio_r),
        .sample_valid(sample_valid),
        .locked      (locked),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A slot is one lrclk half-period: channel, 16-bit word sent MSB-first,
    // and slot length in bclk periods.
    typedef struct {
        bit          ch;
        logic [15:0] word;
        int          len;
    } slot_t;

    slot_t       slots[$];
    bit          lr_q[$];
    bit          d_q[$];
    bit          first_q[$];
    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];
    bit          exp_err;
    logic [15:0] got_l[$];
    logic [15:0] got_r[$];
    time         t_valid;
    time         t_lr_rise;

    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            got_l.push_back(audio_l);
            got_r.push_back(audio_r);
            t_valid = $time;
        end
    end

    function automatic bit slot_bit(input slot_t s, input int q);
        if (q < 16 && q < s.len) return s.word[15-q];
        return 1'b0;
    endfunction

    task automatic add_slot(input bit ch, input logic [15:0] w, input int len);
        slot_t s;
        s.ch = ch; s.word = w; s.len = len;
        slots.push_back(s);
    endtask

    // Serialise slots Philips-style: each slot's bits are delayed by one bclk,
    // so a slot's last bit lands in the first period of the next slot.
    task automatic build();
        lr_q.delete(); d_q.delete(); first_q.delete();
        for (int j = 0; j < slots.size(); j++) begin
            for (int p = 0; p < slots[j].len; p++) begin
                lr_q.push_back(slots[j].ch);
                first_q.push_back(p == 0);
                if (p == 0)
                    d_q.push_back(j == 0 ? 1'b0 : slot_bit(slots[j-1], slots[j-1].len - 1));
                else
                    d_q.push_back(slot_bit(slots[j], p - 1));
            end
        end
    endtask

    // Expected pairs: the first slot is lost to synchronisation, the last one
    // is never closed by an lrclk change; a right word is delivered only
    // when a left word directly precedes it. Short slots keep their top bits.
    task automatic model();
        logic [15:0] hold;
        logic [15:0] m;
        bit          have;
        exp_l.delete(); exp_r.delete();
        exp_err = 1'b0; have = 1'b0; hold = '0;
        for (int j = 1; j < slots.size() - 1; j++) begin
            m = 16'hFFFF;
            if (slots[j].len < 16) begin
                m = ~(m >> slots[j].len);
                exp_err = 1'b1;
            end
            if (slots[j].ch == 1'b0) begin
                hold = slots[j].word & m;
                have = 1'b1;
            end else begin
                if (have) begin
                    exp_l.push_back(hold);
                    exp_r.push_back(slots[j].word & m);
                end
                have = 1'b0;
            end
        end
`ifndef I2S_RX_FRAME_CHECK_EN
        exp_err = 1'b0;
`endif
    endtask

    task automatic play(input int from, input int to, input int half, input int jit);
        int dj;
        for (int i = from; i < to; i++) begin
            i2s_bclk  = 1'b0;
            i2s_lrclk = lr_q[i];
            i2s_din   = d_q[i];
            dj = int'($urandom_range(0, 2 * jit)) - jit;
            #(half + dj);
            i2s_bclk = 1'b1;
            if (first_q[i]) t_lr_rise = $time;
            dj = int'($urandom_range(0, 2 * jit)) - jit;
            #(half + dj);
        end
        i2s_bclk = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_din = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        got_l.delete(); got_r.delete(); slots.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (audio_l !== 16'h0) begin errors++; $display("FAIL reset_audio_l: got %h want 0000", audio_l); end
        checks++; if (audio_r !== 16'h0) begin errors++; $display("FAIL reset_audio_r: got %h want 0000", audio_r); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            add_slot(1'b0, 16'h1234, 32);
            add_slot(1'b1, 16'hABCD, 32);
        end
        add_slot(1'b0, 16'h0000, 32);
        build(); model();
        @(negedge clk);
        play(0, lr_q.size(), 40, 0);
        repeat (12) @(negedge clk);
        checks++; if (got_l.size() != 1) begin errors++; $display("FAIL basic_count: got %0d pulses want 1", got_l.size()); end
        if (got_l.size() >= 1) begin
            checks++; if (got_l[0] !== 16'h1234 || got_r[0] !== 16'hABCD) begin
                errors++; $display("FAIL basic_pair: got %h/%h want 1234/abcd", got_l[0], got_r[0]);
            end
            checks++; if (t_valid - t_lr_rise != (SYNC_STAGES + 2) * 10) begin
                errors++; $display("FAIL basic_latency: got %0d time units want %0d", t_valid - t_lr_rise, (SYNC_STAGES + 2) * 10);
            end
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked: got %b want 1", locked); end
        checks++; if (audio_l !== 16'h1234 || audio_r !== 16'hABCD) begin
            errors++; $display("FAIL basic_hold: got %h/%h want 1234/abcd", audio_l, audio_r);
        end
    endtask

    task automatic test_negative();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, 16'h8000, 16);
            add_slot(1'b1, 16'hFFFF, 16);
        end
        add_slot(1'b0, 16'h0000, 16);
        build(); model();
        play(0, lr_q.size(), 40, 0);
        repeat (12) @(negedge clk);
        checks++; if (got_l.size() != exp_l.size()) begin errors++; $display("FAIL neg_count: got %0d want %0d", got_l.size(), exp_l.size()); end
        for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
            checks++; if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                errors++; $display("FAIL neg_pair%0d: got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
            end
        end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL neg_frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_short_slot();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, 16'hABC0, 12);
            add_slot(1'b1, 16'h5A50, 12);
        end
        add_slot(1'b0, 16'h0000, 12);
        build(); model();
        play(0, lr_q.size(), 40, 0);
        repeat (12) @(negedge clk);
        checks++; if (got_l.size() != exp_l.size()) begin errors++; $display("FAIL short_count: got %0d want %0d", got_l.size(), exp_l.size()); end
        for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
            checks++; if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                errors++; $display("FAIL short_pair%0d: got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
            end
        end
        checks++; if (frame_err !== exp_err) begin errors++; $display("FAIL short_frame_err: got %b want %b", frame_err, exp_err); end
        repeat (60) @(negedge clk);
        checks++; if (frame_err !== exp_err) begin errors++; $display("FAIL short_frame_err_sticky: got %b want %b", frame_err, exp_err); end
    endtask

    task automatic test_mid_word_start();
        int cut;
        do_reset();
        add_slot(1'b1, 16'h7777, 7);   // tail of a right word
        for (int f = 0; f < 2; f++) begin
            add_slot(1'b0, 16'($urandom), 16);
            add_slot(1'b1, 16'($urandom), 16);
        end
        add_slot(1'b0, 16'h0000, 16);
        build(); model();
        cut = 7 + 16 + 16;             // rise that would close the first full right word
        play(0, cut, 40, 0);
        repeat (8) @(negedge clk);
        checks++; if (got_l.size() != 0) begin errors++; $display("FAIL mid_early_valid: got %0d pulses want 0", got_l.size()); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_early_locked: got %b want 0", locked); end
        play(cut, lr_q.size(), 40, 0);
        repeat (12) @(negedge clk);
        checks++; if (got_l.size() != exp_l.size()) begin errors++; $display("FAIL mid_count: got %0d want %0d", got_l.size(), exp_l.size()); end
        for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
            checks++; if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                errors++; $display("FAIL mid_pair%0d: got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
            end
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_locked: got %b want 1", locked); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_reset_mid_stream();
        logic [15:0] l1, r1;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            add_slot(1'b0, 16'($urandom), 16);
            add_slot(1'b1, 16'($urandom), 16);
        end
        add_slot(1'b0, 16'h0000, 16);
        l1 = slots[2].word; r1 = slots[3].word;
        build();
        play(0, 4 * 16 + 8, 40, 0);    // stop halfway through the left slot of frame 2
        checks++; if (got_l.size() != 1 || locked !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got %0d pulses locked=%b want 1 pulse locked=1", got_l.size(), locked);
        end
        checks++; if (audio_l !== l1 || audio_r !== r1) begin
            errors++; $display("FAIL rst_pre_pair: got %h/%h want %h/%h", audio_l, audio_r, l1, r1);
        end
        #3 reset = 1'b1;
        #1;
        checks++; if (audio_l !== 16'h0 || audio_r !== 16'h0 || locked !== 1'b0 || sample_valid !== 1'b0) begin
            errors++; $display("FAIL rst_async: got %h/%h locked=%b valid=%b want 0000/0000 0 0", audio_l, audio_r, locked, sample_valid);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        got_l.delete(); got_r.delete(); slots.delete();
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, 16'($urandom), 16);
            add_slot(1'b1, 16'($urandom), 16);
        end
        add_slot(1'b0, 16'h0000, 16);
        build(); model();
        play(0, lr_q.size(), 40, 0);
        repeat (12) @(negedge clk);
        checks++; if (got_l.size() != exp_l.size()) begin errors++; $display("FAIL rst_post_count: got %0d want %0d", got_l.size(), exp_l.size()); end
        for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
            checks++; if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                errors++; $display("FAIL rst_post_pair%0d: got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_random_frames();
        int bad;
        do_reset();
        for (int f = 0; f < 500; f++) begin
            add_slot(1'b0, 16'($urandom), 16);
            add_slot(1'b1, 16'($urandom), 16);
        end
        add_slot(1'b0, 16'h0000, 16);
        build(); model();
        #($urandom_range(1, 9));
        play(0, lr_q.size(), 20, 2);   // bclk ~ clk/4 with edge jitter
        repeat (12) @(negedge clk);
        checks++; if (got_l.size() != exp_l.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_l.size(), exp_l.size()); end
        bad = 0;
        for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
            checks++; if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                errors++;
                if (bad < 5) $display("FAIL rand_pair%0d: got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
                bad++;
            end
        end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rand_frame_err: got %b want 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_short_slot();
        test_mid_word_start();
        test_reset_mid_stream();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
